// File: rtl/tdc_therm_decoder_pipe_if.sv
// Bus bundle for the TDC thermometer decoder: sample input side, decoded
// output side and the error-counter control/status.
//
// Handshake: in_valid marks a new fine_in/shift sample in the cycle it is
// high; there is no ready, so the decoder accepts one sample every clock.
// out_valid marks the cycle in which fine_out/no_edge/multi_edge carry the
// result of one sample; there is no backpressure on the output either, and
// the outputs simply hold their last value while out_valid is low.
interface tdc_therm_decoder_pipe_if #(
  parameter int NUM_STAGES = 128,
  parameter int OUT_W      = 8,
  parameter int ERR_W      = 16
);
  logic                  in_valid;
  logic [NUM_STAGES-1:0] fine_in;
  logic                  shift;
  logic                  clr_err;
  logic                  out_valid;
  logic [OUT_W-1:0]      fine_out;
  logic                  no_edge;
  logic                  multi_edge;
  logic [ERR_W-1:0]      err_cnt;

  // Producer/consumer of samples (capture registers + combiner side)
  modport master (
    output in_valid, fine_in, shift, clr_err,
    input  out_valid, fine_out, no_edge, multi_edge, err_cnt
  );

  // Decoder side
  modport slave (
    input  in_valid, fine_in, shift, clr_err,
    output out_valid, fine_out, no_edge, multi_edge, err_cnt
  );
endinterface

// File: rtl/tdc_therm_decoder_pipe.sv
// Three-stage thermometer-to-binary decoder for the TDC fine delay line.
//   stage 1: capture tap vector and per-sample polarity
//   stage 2: bubble-tolerant edge match vector
//   stage 3: highest-match priority encode plus quality flags
// A saturating counter tracks how many decoded samples had no edge.
module tdc_therm_decoder_pipe #(
  parameter int NUM_STAGES = 128,
  parameter int BUBBLE_WIN = 4,
  parameter int OUT_W      = 8,
  parameter int ERR_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  tdc_therm_decoder_pipe_if.slave bus
);

  // Number of taps that can be an edge tap; the top BUBBLE_WIN taps only
  // ever serve as the confirmation window of a lower tap.
  localparam int M = NUM_STAGES - BUBBLE_WIN;

  // Elaboration-time parameter sanity checks
  if (BUBBLE_WIN < 1) begin : g_chk_bw
    $error("BUBBLE_WIN must be at least 1");
  end
  if (NUM_STAGES < BUBBLE_WIN + 2) begin : g_chk_ns
    $error("NUM_STAGES must be at least BUBBLE_WIN+2");
  end
  // The all-ones code is reserved for "no edge", so every real code
  // (1 .. M) has to stay strictly below it.
  if (!(((64'd1 << OUT_W) - 64'd1) > 64'(M))) begin : g_chk_ow
    $error("OUT_W too small: 2^OUT_W-1 must exceed NUM_STAGES-BUBBLE_WIN");
  end

  // ---------------------------------------------------------------------
  // Stage 1: capture
  // ---------------------------------------------------------------------
  logic                  s1_valid;
  logic [NUM_STAGES-1:0] s1_fine;
  logic                  s1_shift;

  // Stage-1 valid bit follows in_valid; cleared by reset
  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else     s1_valid <= bus.in_valid;
  end

  // Stage-1 data only loads on a real sample so idle cycles cost no toggles
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      s1_fine  <= bus.fine_in;
      s1_shift <= bus.shift;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: match vector
  // ---------------------------------------------------------------------
  // Normalise polarity so the "leading" level is always 1. A match at i
  // then means tap i is at the leading level and the next BUBBLE_WIN taps
  // are all at the trailing level.
  logic [NUM_STAGES-1:0] lead;
  logic [M-1:0]          m_next;
  logic                  s2_valid;
  logic [M-1:0]          s2_m;

  assign lead = s1_shift ? s1_fine : ~s1_fine;

  // Build the bubble-tolerant match vector
  always_comb begin
    m_next = '0;
    for (int i = 0; i < M; i++) begin
      m_next[i] = lead[i] & ~(|lead[i+1 +: BUBBLE_WIN]);
    end
  end

  // Stage-2 valid bit; cleared by reset
  always_ff @(posedge clk) begin
    if (rst) s2_valid <= 1'b0;
    else     s2_valid <= s1_valid;
  end

  // Stage-2 match register loads only for a real sample
  always_ff @(posedge clk) begin
    if (s1_valid) s2_m <= m_next;
  end

  // ---------------------------------------------------------------------
  // Stage 3: encode
  // ---------------------------------------------------------------------
  logic [OUT_W-1:0] enc_code;
  logic             enc_none;
  logic             enc_multi;

  // Highest set match wins; with no match the code stays all ones.
  // multi is "more than one bit set", found by clearing the lowest set bit.
  always_comb begin
    enc_code = '1;
    for (int i = 0; i < M; i++) begin
      if (s2_m[i]) enc_code = OUT_W'(i + 1);
    end
    enc_none  = ~(|s2_m);
    enc_multi = |(s2_m & (s2_m - M'(1)));
  end

  logic             out_valid_r;
  logic [OUT_W-1:0] fine_out_r;
  logic             no_edge_r;
  logic             multi_edge_r;

  // Output registers: load on a stage-2 sample, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      fine_out_r   <= '1;
      no_edge_r    <= 1'b0;
      multi_edge_r <= 1'b0;
    end else begin
      out_valid_r <= s2_valid;
      if (s2_valid) begin
        fine_out_r   <= enc_code;
        no_edge_r    <= enc_none;
        multi_edge_r <= enc_multi;
      end
    end
  end

  // ---------------------------------------------------------------------
  // No-edge error counter
  // ---------------------------------------------------------------------
  logic [ERR_W-1:0] err_cnt_r;

  // Count presented no-edge results; clear wins over increment; saturate
  always_ff @(posedge clk) begin
    if (rst || bus.clr_err) begin
      err_cnt_r <= '0;
    end else if (out_valid_r && no_edge_r && !(&err_cnt_r)) begin
      err_cnt_r <= err_cnt_r + ERR_W'(1);
    end
  end

  // A sample that reaches the output during the reset cycle was accepted
  // before reset and must not be reported, so out_valid is masked by rst.
  assign bus.out_valid  = out_valid_r & ~rst;
  assign bus.fine_out   = fine_out_r;
  assign bus.no_edge    = no_edge_r;
  assign bus.multi_edge = multi_edge_r;
  assign bus.err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_tdc_therm_decoder_pipe.sv
// Bench for tdc_therm_decoder_pipe: directed cases plus random samples,
// a queue of expected results consumed by an output monitor, and a
// cycle-level model of the saturating error counter (16-bit and 2-bit builds).
module tb_tdc_therm_decoder_pipe;
  localparam int NS = 128;
  localparam int BW = 4;
  localparam int OW = 8;
  localparam int EW = 42; // {issue_cyc[31:0], multi, none, code[7:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT wiring ----------------
  logic          in_valid = 1'b0;
  logic [NS-1:0] fine_in  = '0;
  logic          shift    = 1'b0;
  logic          clr_err  = 1'b0;

  tdc_therm_decoder_pipe_if #(.NUM_STAGES(NS), .OUT_W(OW), .ERR_W(16)) bif ();
  tdc_therm_decoder_pipe_if #(.NUM_STAGES(NS), .OUT_W(OW), .ERR_W(2))  bif2 ();

  assign bif.in_valid  = in_valid;
  assign bif.fine_in   = fine_in;
  assign bif.shift     = shift;
  assign bif.clr_err   = clr_err;
  assign bif2.in_valid = in_valid;
  assign bif2.fine_in  = fine_in;
  assign bif2.shift    = shift;
  assign bif2.clr_err  = clr_err;

  tdc_therm_decoder_pipe #(.NUM_STAGES(NS), .BUBBLE_WIN(BW), .OUT_W(OW), .ERR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  tdc_therm_decoder_pipe #(.NUM_STAGES(NS), .BUBBLE_WIN(BW), .OUT_W(OW), .ERR_W(2)) dut_e2 (
    .clk (clk),
    .rst (rst),
    .bus (bif2)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  logic [OW-1:0] hold_fine = '1;
  logic          hold_ne   = 1'b0;
  logic          hold_me   = 1'b0;
  logic [15:0]   exp_err16 = '0;
  logic [1:0]    exp_err2  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // Reference: scan every candidate tap, list those whose level is the
  // leading level and whose next BW taps are all the trailing level.
  function automatic void ref_decode(input logic [NS-1:0] v, input logic sh,
                                     output logic [OW-1:0] code, output logic ne,
                                     output logic me);
    int hits;
    int top;
    hits = 0;
    top  = -1;
    for (int i = 0; i <= NS - BW - 1; i++) begin
      bit ok;
      ok = (v[i] == sh);
      for (int j = 1; j <= BW; j++) if (v[i+j] == sh) ok = 1'b0;
      if (ok) begin
        hits++;
        top = i;
      end
    end
    ne   = (hits == 0);
    me   = (hits > 1);
    code = ne ? {OW{1'b1}} : OW'(top + 1);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic iv, input logic [NS-1:0] v, input logic sh,
                       input logic clr, input logic rs);
    logic [OW-1:0] c;
    logic ne, me;
    @(posedge clk);
    #1;
    in_valid = iv;
    fine_in  = v;
    shift    = sh;
    clr_err  = clr;
    rst      = rs;
    if (iv && !rs) begin
      ref_decode(v, sh, c, ne, me);
      exp_q.push_back({32'(cyc), me, ne, c});
    end
  endtask

  function automatic logic [NS-1:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Thermometer with p leading taps at the level implied by sh
  function automatic logic [NS-1:0] therm(input int p, input logic sh);
    logic [NS-1:0] v;
    for (int i = 0; i < NS; i++) v[i] = (i < p) ? sh : ~sh;
    return v;
  endfunction

  task automatic send(input logic [NS-1:0] v, input logic sh);
    drive(1'b1, v, sh, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, rand_vec(), 1'($urandom), 1'b0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    bit popped_ne;
    if (mon_en) begin
      popped_ne = 1'b0;
      chk("err_cnt", 64'(bif.err_cnt), 64'(exp_err16));
      chk("err_cnt_w2", 64'(bif2.err_cnt), 64'(exp_err2));
      if (rst) begin
        chk("out_valid_in_reset", 64'(bif.out_valid), 64'd0);
        exp_q.delete();
        hold_fine = '1;
        hold_ne   = 1'b0;
        hold_me   = 1'b0;
      end else if (bif.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 64'(bif.out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("fine_out", 64'(bif.fine_out), 64'(e[7:0]));
          chk("no_edge", 64'(bif.no_edge), 64'(e[8]));
          chk("multi_edge", 64'(bif.multi_edge), 64'(e[9]));
          chk("latency", 64'(cyc - int'(e[41:10])), 64'd3);
          popped_ne = e[8];
          hold_fine = e[7:0];
          hold_ne   = e[8];
          hold_me   = e[9];
        end
      end else begin
        chk("hold_fine_out", 64'(bif.fine_out), 64'(hold_fine));
        chk("hold_flags", 64'({bif.no_edge, bif.multi_edge}), 64'({hold_ne, hold_me}));
      end
      // Counter model: the presented no-edge result is counted at the next edge
      if (rst || clr_err) begin
        exp_err16 = '0;
        exp_err2  = '0;
      end else if (popped_ne) begin
        if (exp_err16 != 16'hFFFF) exp_err16 = exp_err16 + 16'd1;
        if (exp_err2 != 2'd3) exp_err2 = exp_err2 + 2'd1;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [NS-1:0] v;
  initial begin
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Basic edge
    send(therm(37, 1'b1), 1'b1);
    idle(4);

    // Bubble tolerance
    v = therm(21, 1'b1); v[30] = 1'b1;
    send(v, 1'b1);
    v = therm(37, 1'b1); v[38] = 1'b1;
    send(v, 1'b1);
    idle(4);

    // Inverted polarity and back-to-back streaming
    send(therm(50, 1'b0), 1'b0);
    send(therm(10, 1'b1), 1'b1);
    idle(4);

    // Range boundary
    send(therm(124, 1'b1), 1'b1);
    send(therm(125, 1'b1), 1'b1);
    idle(4);

    // Error counter: clear, five no-edge samples, then clear against an increment
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) send('0, 1'b1);
    idle(4);
    send('0, 1'b1);
    idle(2);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    idle(3);

    // Reset mid-stream, including a sample offered during the reset cycle
    for (int k = 0; k < 3; k++) send(therm($urandom_range(0, NS), 1'b1), 1'b1);
    drive(1'b1, therm(40, 1'b1), 1'b1, 1'b0, 1'b1);
    idle(5);
    send(therm(77, 1'b0), 1'b0);
    idle(5);

    // Random samples: clean, bubbled, and fully random vectors
    for (int n = 0; n < 300; n++) begin
      int mode;
      logic sh;
      logic iv;
      mode = $urandom_range(0, 9);
      sh   = 1'($urandom);
      iv   = ($urandom_range(0, 3) != 0);
      if (mode == 0) begin
        v = rand_vec();
      end else begin
        v = therm($urandom_range(0, NS), sh);
        if (mode < 4) begin
          for (int f = 0; f < $urandom_range(1, 3); f++) begin
            int b;
            b = $urandom_range(0, NS - 1);
            v[b] = ~v[b];
          end
        end
      end
      drive(iv, v, sh, ($urandom_range(0, 39) == 0), 1'b0);
    end
    idle(6);

    mon_en = 1'b0;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
